// File: rtl/grid_cursor_if.sv
// Joystick-sample / cursor-position bundle between the sampler, grid_cursor and the board logic.
// The master drives the samples and the enable; the slave returns the cursor position and event pulses.
interface grid_cursor_if #(
  parameter int DATA_W = 10,
  parameter int COLS   = 3,
  parameter int ROWS   = 3,
  parameter int POS_W  = $clog2(COLS*ROWS)
);
  logic [DATA_W-1:0]        Xdata;
  logic [DATA_W-1:0]        Ydata;
  logic                     enable;
  logic [$clog2(COLS)-1:0]  Xpos;
  logic [$clog2(ROWS)-1:0]  Ypos;
  logic [POS_W-1:0]         position;
  logic                     move_pulse;
  logic                     bump_pulse;

  modport master (
    output Xdata, Ydata, enable,
    input  Xpos, Ypos, position, move_pulse, bump_pulse
  );

  modport slave (
    input  Xdata, Ydata, enable,
    output Xpos, Ypos, position, move_pulse, bump_pulse
  );
endinterface

// File: rtl/grid_cursor.sv
// Joystick-to-grid cursor: decodes a deflection into one of four directions and steps a
// COLS x ROWS cursor on release, with optional hold-to-repeat, edge wrap and move/bump pulses.
module grid_cursor #(
  parameter int COLS         = 3,
  parameter int ROWS         = 3,
  parameter int DATA_W       = 10,
  parameter int LOW_THRESH   = 200,
  parameter int HIGH_THRESH  = 800,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1,
  parameter int POS_W        = $clog2(COLS*ROWS)
) (
  input logic         clk,
  input logic         rst,
  grid_cursor_if.slave bus
);
  localparam int X_W     = $clog2(COLS);
  localparam int Y_W     = $clog2(ROWS);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [DATA_W-1:0] LOW        = DATA_W'(LOW_THRESH);
  localparam logic [DATA_W-1:0] HIGH       = DATA_W'(HIGH_THRESH);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0]    X_CENTRE   = X_W'((COLS - 1) / 2);
  localparam logic [Y_W-1:0]    Y_CENTRE   = Y_W'((ROWS - 1) / 2);
  localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {NEUTRAL = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
  typedef enum logic [1:0] {DIR_DOWN = 2'd0, DIR_UP = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

  state_t            state_reg, state_next;
  dir_t              dir_reg, dir_next, dir_decoded;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [X_W-1:0]    xpos_reg, xpos_next;
  logic [Y_W-1:0]    ypos_reg, ypos_next;
  logic              move_reg, move_next;
  logic              bump_reg, bump_next;
  logic              do_move;
  logic              x_hi, x_lo, y_hi, y_lo, deflected, centred;

  // Samples equal to a threshold are neither centred nor deflected.
  always_comb begin
    x_hi      = bus.Xdata > HIGH;
    x_lo      = bus.Xdata < LOW;
    y_hi      = bus.Ydata > HIGH;
    y_lo      = bus.Ydata < LOW;
    deflected = x_hi | x_lo | y_hi | y_lo;
    centred   = (bus.Xdata > LOW) && (bus.Xdata < HIGH) &&
                (bus.Ydata > LOW) && (bus.Ydata < HIGH);
    if (y_hi)      dir_decoded = DIR_DOWN;
    else if (y_lo) dir_decoded = DIR_UP;
    else if (x_hi) dir_decoded = DIR_LEFT;
    else           dir_decoded = DIR_RIGHT;
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    do_move    = 1'b0;
    if (!bus.enable) begin
      state_next = NEUTRAL;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        NEUTRAL: begin
          if (deflected) begin
            dir_next   = dir_decoded;
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (centred) begin
            do_move    = 1'b1;
            state_next = NEUTRAL;
            cnt_next   = '0;
          end else if (REPEAT_DELAY != 0) begin
            if (cnt_reg == DELAY_LAST) begin
              do_move    = 1'b1;
              state_next = REPEAT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (centred) begin
            state_next = NEUTRAL;
            cnt_next   = '0;
          end else if (cnt_reg == RATE_LAST) begin
            do_move  = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = NEUTRAL;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A blocked step at an edge becomes a bump instead of a move when wrapping is off.
  always_comb begin
    xpos_next = xpos_reg;
    ypos_next = ypos_reg;
    move_next = 1'b0;
    bump_next = 1'b0;
    if (do_move) begin
      move_next = 1'b1;
      case (dir_reg)
        DIR_DOWN: begin
          if (ypos_reg != '0)   ypos_next = ypos_reg - Y_W'(1);
          else if (WRAP != 0)   ypos_next = Y_LAST;
          else begin            move_next = 1'b0; bump_next = 1'b1; end
        end
        DIR_UP: begin
          if (ypos_reg != Y_LAST) ypos_next = ypos_reg + Y_W'(1);
          else if (WRAP != 0)     ypos_next = '0;
          else begin              move_next = 1'b0; bump_next = 1'b1; end
        end
        DIR_LEFT: begin
          if (xpos_reg != '0)   xpos_next = xpos_reg - X_W'(1);
          else if (WRAP != 0)   xpos_next = X_LAST;
          else begin            move_next = 1'b0; bump_next = 1'b1; end
        end
        default: begin
          if (xpos_reg != X_LAST) xpos_next = xpos_reg + X_W'(1);
          else if (WRAP != 0)     xpos_next = '0;
          else begin              move_next = 1'b0; bump_next = 1'b1; end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= NEUTRAL;
      dir_reg   <= DIR_DOWN;
      cnt_reg   <= '0;
      xpos_reg  <= X_CENTRE;
      ypos_reg  <= Y_CENTRE;
      move_reg  <= 1'b0;
      bump_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      xpos_reg  <= xpos_next;
      ypos_reg  <= ypos_next;
      move_reg  <= move_next;
      bump_reg  <= bump_next;
    end
  end

  assign bus.Xpos       = xpos_reg;
  assign bus.Ypos       = ypos_reg;
  assign bus.position   = POS_W'(COLS * int'(ypos_reg) + int'(xpos_reg));
  assign bus.move_pulse = move_reg;
  assign bus.bump_pulse = bump_reg;
endmodule

// File: tb/tb_grid_cursor.sv
// Directed bench for grid_cursor: two 3x3 cursors (saturating and wrapping) driven in lockstep,
// plus a 5x5 cursor with hold-to-repeat.
module tb_grid_cursor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  grid_cursor_if                       if_a();
  grid_cursor_if                       if_b();
  grid_cursor_if #(.COLS(5), .ROWS(5)) if_c();

  grid_cursor #(.COLS(3), .ROWS(3), .WRAP(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  grid_cursor #(.COLS(3), .ROWS(3), .WRAP(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  grid_cursor #(.COLS(5), .ROWS(5), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(3))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input int x, input int y);
    if_a.Xdata = 10'(x); if_a.Ydata = 10'(y);
    if_b.Xdata = 10'(x); if_b.Ydata = 10'(y);
  endtask

  task automatic set_c(input int x, input int y);
    if_c.Xdata = 10'(x); if_c.Ydata = 10'(y);
  endtask

  initial begin
    int exp_mb;
    if_a.enable = 1'b1; if_b.enable = 1'b1; if_c.enable = 1'b1;
    set_ab(512, 512);
    set_c(512, 512);
    step(2);
    rst = 1'b0;
    check("reset_pos_a", int'(if_a.position), 4);
    check("reset_pos_b", int'(if_b.position), 4);
    check("reset_pos_c", int'(if_c.position), 12);
    check("reset_pulses_a", int'({if_a.move_pulse, if_a.bump_pulse}), 0);

    // Hold RIGHT for 5 cycles, then release: one move to column 2.
    set_ab(100, 512);
    step(1);
    check("held_entry_no_move", int'(if_a.move_pulse), 0);
    step(4);
    check("held_no_move", int'(if_a.move_pulse), 0);
    set_ab(512, 512);
    step(1);
    check("release_move_a", int'(if_a.move_pulse), 1);
    check("release_xpos_a", int'(if_a.Xpos), 2);
    check("release_pos_a", int'(if_a.position), 5);
    check("release_pos_b", int'(if_b.position), 5);
    step(1);
    check("move_one_cycle", int'(if_a.move_pulse), 0);

    // RIGHT at the right edge: bump without wrap, wrap to column 0 with it.
    set_ab(100, 512);
    step(3);
    set_ab(512, 512);
    step(1);
    check("edge_bump_a", int'(if_a.bump_pulse), 1);
    check("edge_nomove_a", int'(if_a.move_pulse), 0);
    check("edge_pos_a", int'(if_a.position), 5);
    check("wrap_move_b", int'(if_b.move_pulse), 1);
    check("wrap_xpos_b", int'(if_b.Xpos), 0);
    check("wrap_pos_b", int'(if_b.position), 3);
    step(1);
    check("bump_one_cycle", int'(if_a.bump_pulse), 0);

    // DOWN beats RIGHT; a later LEFT deflection while held is ignored.
    set_ab(100, 900);
    step(1);
    set_ab(900, 512);
    step(2);
    check("prio_held_no_move", int'(if_a.move_pulse), 0);
    set_ab(512, 512);
    step(1);
    check("prio_move_a", int'(if_a.move_pulse), 1);
    check("prio_ypos_a", int'(if_a.Ypos), 0);
    check("prio_xpos_a", int'(if_a.Xpos), 2);
    check("prio_pos_b", int'(if_b.position), 0);

    // Samples exactly on a threshold leave NEUTRAL alone.
    set_ab(200, 512);
    step(3);
    set_ab(800, 512);
    step(3);
    set_ab(512, 512);
    step(1);
    check("thresh_no_bump_a", int'(if_a.bump_pulse), 0);
    check("thresh_no_move_b", int'(if_b.move_pulse), 0);
    check("thresh_pos_b", int'(if_b.position), 0);

    // From HELD, a threshold-equal sample is not a release.
    set_ab(100, 512);
    step(1);
    set_ab(200, 512);
    step(2);
    check("held_thresh_no_bump_a", int'(if_a.bump_pulse), 0);
    check("held_thresh_no_move_b", int'(if_b.move_pulse), 0);
    set_ab(512, 512);
    step(1);
    check("held_release_bump_a", int'(if_a.bump_pulse), 1);
    check("held_release_move_b", int'(if_b.move_pulse), 1);
    check("held_release_pos_b", int'(if_b.position), 1);

    // enable=0 mid-HELD discards the pending release move.
    set_ab(100, 512);
    step(2);
    if_a.enable = 1'b0; if_b.enable = 1'b0;
    step(1);
    check("disable_no_pulse_b", int'({if_b.move_pulse, if_b.bump_pulse}), 0);
    set_ab(512, 512);
    if_a.enable = 1'b1; if_b.enable = 1'b1;
    step(1);
    check("disable_no_move_b", int'(if_b.move_pulse), 0);
    check("disable_no_bump_a", int'(if_a.bump_pulse), 0);
    check("disable_pos_a", int'(if_a.position), 2);
    check("disable_pos_b", int'(if_b.position), 1);

    // Hold UP for 20 cycles on the 5x5 grid: moves at 4 and 7, then bumps every 3 cycles.
    set_c(512, 50);
    for (int k = 0; k < 20; k++) begin
      step(1);
      exp_mb = 0;
      if (k == 4 || k == 7) exp_mb = 2;
      if (k == 10 || k == 13 || k == 16 || k == 19) exp_mb = 1;
      check($sformatf("repeat_k%0d_move_bump", k), int'({if_c.move_pulse, if_c.bump_pulse}), exp_mb);
    end
    set_c(512, 512);
    step(1);
    check("repeat_release_no_pulse", int'({if_c.move_pulse, if_c.bump_pulse}), 0);
    check("repeat_ypos_c", int'(if_c.Ypos), 4);
    check("repeat_pos_c", int'(if_c.position), 22);

    // Reset mid-REPEAT: no pulse, back to centre, back in NEUTRAL.
    set_c(512, 900);
    step(5);
    check("pre_rst_move_c", int'(if_c.move_pulse), 1);
    check("pre_rst_ypos_c", int'(if_c.Ypos), 3);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_no_pulse_c", int'({if_c.move_pulse, if_c.bump_pulse}), 0);
    check("rst_pos_c", int'(if_c.position), 12);
    check("rst_pos_a", int'(if_a.position), 4);
    set_c(512, 512);
    step(1);
    check("rst_release_no_move_c", int'(if_c.move_pulse), 0);
    check("rst_final_pos_c", int'(if_c.position), 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
- Parametrised joystick-to-grid cursor controller. Generalises the fixed 3x3 board cursor to a COLS x ROWS grid.
- Adds configurable thresholds, optional edge wrap-around, hold-to-auto-repeat, and move/bump event pulses.
- Sits between the analog joystick sampler (10-bit X/Y words) and the board/game logic, which consumes the linear cell index.

Parameters:
- COLS, 3, grid columns (>=2).
- ROWS, 3, grid rows (>=2).
- DATA_W, 10, joystick sample width.
- LOW_THRESH, 200, deflection threshold; a sample strictly below it is deflected low.
- HIGH_THRESH, 800, deflection threshold; a sample strictly above it is deflected high.
- WRAP, 0, 1 = cursor wraps at grid edges; 0 = cursor saturates at grid edges.
- REPEAT_DELAY, 0, hold cycles before the first auto-repeat move; 0 disables auto-repeat.
- REPEAT_RATE, 1, cycles between subsequent auto-repeat moves (>=1).
- POS_W, $clog2(COLS*ROWS), width of position.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- Xdata  input  DATA_W  joystick X sample.
- Ydata  input  DATA_W  joystick Y sample.
- enable  input  1  1 = cursor accepts input; 0 = FSM forced to NEUTRAL, no moves.
- Xpos  output  $clog2(COLS)  current column.
- Ypos  output  $clog2(ROWS)  current row.
- position  output  POS_W  linear index, Xpos + COLS*Ypos (combinational from registers).
- move_pulse  output  1  one-cycle pulse when Xpos or Ypos changes.
- bump_pulse  output  1  one-cycle pulse when a move is blocked at an edge (WRAP=0 only).

Behaviour:
- Reset (rst=1 at posedge): Xpos=(COLS-1)/2, Ypos=(ROWS-1)/2, state NEUTRAL, hold counter 0, move_pulse=0, bump_pulse=0. Reset has priority over everything, including a mid-hold or mid-repeat sequence.
- centred = LOW_THRESH < X < HIGH_THRESH AND LOW_THRESH < Y < HIGH_THRESH (strict on both axes). A sample exactly equal to a threshold is neither centred nor deflected, so the FSM holds its state.
- Direction decode, priority highest first:
  - Y > HIGH gives DOWN (Ypos-1).
  - Y < LOW gives UP (Ypos+1).
  - X > HIGH gives LEFT (Xpos-1).
  - X < LOW gives RIGHT (Xpos+1).
- FSM states: NEUTRAL, HELD, REPEAT. Direction register dir is latched on NEUTRAL->HELD and ignored thereafter until NEUTRAL is re-entered.
- NEUTRAL: if a direction is decoded, latch dir, go HELD, counter=0. No move on the entry cycle.
- HELD:
  - If centred: apply one move of dir, go NEUTRAL (move-on-release).
  - Else, if REPEAT_DELAY != 0: counter increments each cycle. When counter == REPEAT_DELAY-1, apply a move, go REPEAT, counter=0.
- REPEAT:
  - If centred: go NEUTRAL with no additional move.
  - Else counter increments; when counter == REPEAT_RATE-1, apply a move, counter=0.
- Move application, registered: the new Xpos/Ypos and the pulse are visible the cycle after the deciding edge.
  - In range: step the axis, move_pulse=1.
  - At an edge with WRAP=1: wrap 0<->COLS-1 (or 0<->ROWS-1), move_pulse=1.
  - At an edge with WRAP=0: position unchanged, bump_pulse=1, move_pulse=0.
- move_pulse and bump_pulse are never asserted together and never held for two consecutive cycles from one decision.
- enable=0: state->NEUTRAL, counter=0, pulses 0, position held. A pending release move is discarded.
- Default/illegal state encodings recover to NEUTRAL on the next edge.

Test Plan:
- Reset, COLS=ROWS=3: position=4. Drive X=100 for 5 cycles, then X=Y=512: exactly one move_pulse, Xpos=2, position=5.
- WRAP=0, Xpos=2: RIGHT deflect then release -> bump_pulse=1 for 1 cycle, position stays 5. Same with WRAP=1 -> Xpos=0, move_pulse=1.
- REPEAT_DELAY=4, REPEAT_RATE=3, 5x5 grid from centre (12): hold Y=50 for 20 cycles then centre -> moves at hold cycles 4, 7, 10, 13, 16, 19. Ypos saturates at 4 and later decisions bump. No move on release.
- Priority: X=100 and Y=900 in the same cycle -> DOWN latched. Switching to X=900 while held is ignored. Release -> Ypos-1 only.
- Threshold edges: X=200 or X=800 with Y=512 -> no transition from NEUTRAL. From HELD, X=200 does not count as release.
- rst asserted mid-REPEAT, and separately enable=0 mid-HELD -> next cycle state NEUTRAL with no pulse. After rst, position returns to centre. After enable=0, position is unchanged.
